// File: rtl/arb_requester_pkg.sv
// arb_requester_pkg: shared types and defaults for the requester front end.
// Holds the per-channel FSM encoding and default parameter values.
package arb_requester_pkg;

    localparam int N_DEF       = 4;
    localparam int LEN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;
    localparam int GAP_DEF     = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10,
        ST_ERR  = 2'b11
    } ch_state_e;

endpackage

// File: rtl/arb_requester_if.sv
// arb_requester_if: bundle between bus-master clients / arbiter and the requester.
// slave: requester side (start, len, grant, clr_err in; req, beat, busy, done,
// timeout_err, gnt_err out). master: the mirror image for clients/arbiter.
interface arb_requester_if
    import arb_requester_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LEN_W = LEN_W_DEF
) ();

    logic [N-1:0]       start;
    logic [N*LEN_W-1:0] len;
    logic [N-1:0]       grant;
    logic [N-1:0]       clr_err;
    logic [N-1:0]       req;
    logic [N-1:0]       beat;
    logic [N-1:0]       busy;
    logic [N-1:0]       done;
    logic [N-1:0]       timeout_err;
    logic               gnt_err;

    modport slave (
        input  start, len, grant, clr_err,
        output req, beat, busy, done, timeout_err, gnt_err
    );

    modport master (
        output start, len, grant, clr_err,
        input  req, beat, busy, done, timeout_err, gnt_err
    );

endinterface

// File: rtl/arb_req_channel.sv
// arb_req_channel: one requester channel (IDLE/REQ/GAP/ERR) with beat, wait
// and gap counters. Ports: clk, rst (sync, active low), start_i, len_i,
// grant_i, clr_err_i in; req_o, busy_o, done_o, timeout_err_o out.
module arb_req_channel
    import arb_requester_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             grant_i,
    input  logic             clr_err_i,
    output logic             req_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_err_o
);

    localparam int REM_W  = LEN_W + 1;
    localparam int WCNT_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [REM_W-1:0]  REM_ONE   = REM_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    ch_state_e         state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rem_d   = {1'b0, len_i} + REM_ONE;
                    wcnt_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant_i) begin
                    rem_d  = rem_q - REM_ONE;
                    wcnt_d = '0;
                    if (rem_q == REM_ONE) begin
                        done_d  = 1'b1;
                        gcnt_d  = '0;
                        // With no gap the channel may accept a start right away.
                        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            ST_ERR: begin
                // A start arriving with clr_err is dropped, not queued.
                if (clr_err_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_o         = (state_q == ST_REQ);
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_err_o = (state_q == ST_ERR);
    assign done_o        = done_q;

endmodule

// File: rtl/arb_requester.sv
// arb_requester: N independent requester channels plus a grant protocol checker.
// Ports: clk, rst (sync, active low), bus (arb_requester_if.slave).
module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF
) (
    input logic              clk,
    input logic              rst,
    arb_requester_if.slave   bus
);

    logic [N-1:0] req_w;
    logic [N-1:0] busy_w;
    logic [N-1:0] done_w;
    logic [N-1:0] terr_w;
    logic         gnt_bad;
    logic         gnt_err_q, gnt_err_d;

    for (genvar g = 0; g < N; g++) begin : g_ch
        arb_req_channel #(
            .LEN_W   (LEN_W),
            .TIMEOUT (TIMEOUT),
            .GAP     (GAP)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .start_i       (bus.start[g]),
            .len_i         (bus.len[g*LEN_W +: LEN_W]),
            .grant_i       (bus.grant[g]),
            .clr_err_i     (bus.clr_err[g]),
            .req_o         (req_w[g]),
            .busy_o        (busy_w[g]),
            .done_o        (done_w[g]),
            .timeout_err_o (terr_w[g])
        );
    end

    // Violation: a grant without a request, or more than one grant bit.
    always_comb begin
        gnt_bad   = (|(bus.grant & ~req_w)) ||
                    (|(bus.grant & (bus.grant - N'(1))));
        gnt_err_d = gnt_err_q | gnt_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    assign bus.req         = req_w;
    assign bus.beat        = req_w & bus.grant;
    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.timeout_err = terr_w;
    assign bus.gnt_err     = gnt_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed bench for arb_requester with a done-event
// scoreboard and a small round-robin arbiter model for grant.
module tb_arb_requester;

    localparam int N  = 4;
    localparam int LW = 4;

    typedef enum int {G_MAN, G_TIED, G_ARB} gmode_e;
    typedef struct {
        int ch;
        int cy;
    } dexp_t;

    logic       clk = 1'b0;
    logic       rst;
    gmode_e     mode;
    logic [3:0] gman;
    logic [3:0] gnt;
    logic [1:0] ptr;
    logic [1:0] ix;
    int         cyc;
    int         total;
    int         bad;
    int         bcnt [4];
    int         bs [4];
    int         c0;
    int         b0;
    dexp_t      dq [$];
    dexp_t      e;

    always #5 clk = ~clk;

    arb_requester_if #(.N(N), .LEN_W(LW)) bus ();

    arb_requester #(
        .N       (N),
        .LEN_W   (LW),
        .TIMEOUT (16),
        .GAP     (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        gnt = '0;
        ix  = ptr;
        case (mode)
            G_MAN:  gnt = gman;
            G_TIED: gnt = bus.req;
            default: begin
                for (int k = 0; k < 4; k++) begin
                    ix = ptr + 2'(k);
                    if (gnt == 4'b0 && bus.req[ix]) gnt[ix] = 1'b1;
                end
            end
        endcase
    end

    assign bus.grant = gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= 2'd0;
        end else if (mode == G_ARB) begin
            for (int k = 0; k < 4; k++) begin
                if (gnt[k]) ptr <= 2'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(int ch, int l);
        bus.start = '0;
        bus.start[ch] = 1'b1;
        bus.len[ch*LW +: LW] = 4'(l);
    endtask

    // Monitor: beat tally and done-pulse scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.beat[i]) bcnt[i]++;
                if (bus.done[i]) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected ch=%0d cyc=%0d expected none", i, cyc);
                    end else begin
                        e = dq.pop_front();
                        if (e.ch != i || e.cy != cyc) begin
                            bad++;
                            $display("FAIL done_event actual ch=%0d cyc=%0d expected ch=%0d cyc=%0d",
                                     i, cyc, e.ch, e.cy);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst         = 1'b0;
        mode        = G_MAN;
        gman        = '0;
        bus.start   = '0;
        bus.len     = '0;
        bus.clr_err = '0;
        tick(2);
        chk("rst_req", int'(bus.req), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_terr", int'(bus.timeout_err), 0);
        chk("rst_gnterr", int'(bus.gnt_err), 0);
        rst = 1'b1;

        // Burst len=2 on ch0 with grant tied to req.
        mode = G_TIED;
        go(0, 2);
        c0 = cyc;
        b0 = bcnt[0];
        dq.push_back('{0, c0 + 4});
        tick();
        bus.start = '0;
        chk("t1_req_first", int'(bus.req[0]), 1);
        tick(2);
        chk("t1_req_last", int'(bus.req[0]), 1);
        tick();
        chk("t1_req_fall", int'(bus.req[0]), 0);
        chk("t1_busy_gap", int'(bus.busy[0]), 1);
        tick();
        chk("t1_busy_idle", int'(bus.busy[0]), 0);
        chk("t1_beats", bcnt[0] - b0, 3);

        // ch1 len=1, grant only every 4th cycle.
        mode = G_MAN;
        gman = '0;
        go(1, 1);
        c0 = cyc;
        b0 = bcnt[1];
        dq.push_back('{1, c0 + 9});
        for (int k = 1; k <= 9; k++) begin
            tick();
            bus.start = '0;
            gman = (k == 4 || k == 8) ? 4'b0010 : 4'b0000;
            if (k == 8) chk("t2_req_hold", int'(bus.req[1]), 1);
            if (k == 9) begin
                chk("t2_req_fall", int'(bus.req[1]), 0);
                chk("t2_terr", int'(bus.timeout_err[1]), 0);
            end
        end
        tick();
        chk("t2_beats", bcnt[1] - b0, 2);

        // ch2 len=0, never granted: timeout then clear.
        go(2, 0);
        c0 = cyc;
        tick();
        bus.start = '0;
        tick(15);
        chk("t3_req_16th", int'(bus.req[2]), 1);
        tick();
        chk("t3_req_fall", int'(bus.req[2]), 0);
        chk("t3_terr", int'(bus.timeout_err[2]), 1);
        chk("t3_busy_err", int'(bus.busy[2]), 1);
        bus.clr_err[2] = 1'b1;
        bus.start[2]   = 1'b1;
        tick();
        bus.clr_err = '0;
        bus.start   = '0;
        chk("t3_busy_clr", int'(bus.busy[2]), 0);
        chk("t3_terr_clr", int'(bus.timeout_err[2]), 0);
        tick();
        chk("t3_start_ignored", int'(bus.req[2]), 0);

        // Spurious grant, then multi-hot grant.
        gman = 4'b1000;
        tick();
        gman = '0;
        chk("t4_spurious", int'(bus.gnt_err), 1);
        tick(3);
        chk("t4_sticky", int'(bus.gnt_err), 1);
        rst = 1'b0;
        tick();
        chk("t4_rst_clear", int'(bus.gnt_err), 0);
        rst = 1'b1;
        bus.start = 4'b0011;
        bus.len   = 16'h00FF;
        tick();
        bus.start = '0;
        chk("t4_two_req", int'(bus.req), 3);
        gman = 4'b0011;
        tick();
        gman = '0;
        chk("t4_multihot", int'(bus.gnt_err), 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t4_rst_req", int'(bus.req), 0);

        // Reset during beat 2 of len=3, then a clean burst.
        mode = G_TIED;
        go(3, 3);
        tick();
        bus.start = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_req", int'(bus.req), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_done", int'(bus.done), 0);
        rst = 1'b1;
        tick();
        go(3, 3);
        c0 = cyc;
        b0 = bcnt[3];
        dq.push_back('{3, c0 + 5});
        tick();
        bus.start = '0;
        tick(5);
        chk("t5_busy_end", int'(bus.busy[3]), 0);
        chk("t5_beats", bcnt[3] - b0, 4);

        // All channels through the round-robin model.
        rst  = 1'b0;
        mode = G_ARB;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) bs[i] = bcnt[i];
        bus.start = 4'hF;
        bus.len   = 16'h1111;
        c0 = cyc;
        dq.push_back('{0, c0 + 6});
        dq.push_back('{1, c0 + 7});
        dq.push_back('{2, c0 + 8});
        dq.push_back('{3, c0 + 9});
        tick();
        bus.start = '0;
        tick();
        bus.start[0] = 1'b1;
        tick();
        bus.start = '0;
        tick(7);
        chk("t6_req_idle", int'(bus.req), 0);
        for (int i = 0; i < 4; i++) chk($sformatf("t6_beats_ch%0d", i), bcnt[i] - bs[i], 2);
        chk("t6_gnterr", int'(bus.gnt_err), 0);

        tick(2);
        chk("done_missing", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side front end for the 4-way round-robin arbiter: converts local burst commands into arbiter `req` lines and consumes `grant`.
- Per channel: raises `req`, counts granted cycles as data beats until the burst completes, then releases `req` for a minimum gap.
- Flags grant starvation (timeout) and grant protocol violations (spurious or non-one-hot grant).
- Sits between the bus-master clients and the arbiter; its `req` output connects directly to the arbiter's `req` input.

Parameters:
- N, 4: number of requester channels; equals the arbiter width.
- LEN_W, 4: width of the per-channel burst length field; beats = len+1 (1..16).
- TIMEOUT, 16: consecutive ungranted cycles in REQ before the channel aborts; must be ≥1.
- GAP, 1: cycles with `req` low after a burst before the channel returns to IDLE; 0 is allowed.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous active-low reset.
- start, input, N: per-channel burst command; sampled only in IDLE.
- len, input, N*LEN_W: channel i length at [i*LEN_W +: LEN_W]; sampled with start.
- grant, input, N: from the arbiter; combinational function of `req`.
- req, output, N: registered request to the arbiter.
- beat, output, N: combinational `req[i] & grant[i]`; one data beat transferred this cycle.
- busy, output, N: registered; high in REQ, GAP and ERR.
- done, output, N: registered one-cycle pulse after the final beat.
- timeout_err, output, N: sticky; high while the channel is in ERR.
- clr_err, input, N: clears channel ERR.
- gnt_err, output, 1: sticky protocol-violation flag; cleared only by reset.

Behaviour:
- **Reset (rst=0 at an edge):**
  - All channels go to IDLE; all counters are 0.
  - req, busy, done, timeout_err and gnt_err are all 0.
  - Reset mid-burst aborts the burst with no done pulse.
- **Per-channel FSM:** states IDLE, REQ, GAP, ERR.
- **IDLE:**
  - If start[i]=1: rem ← len+1, wcnt ← 0, go to REQ.
  - req goes high and busy goes high at the next edge (1-cycle latency).
- **REQ (req[i]=1):**
  - If grant[i]=1:
    - Beat; rem decrements and wcnt ← 0.
    - If rem==1 (last beat): go to GAP (or IDLE if GAP=0), done pulses high for the next cycle, and req falls at that same edge.
  - If grant[i]=0:
    - If wcnt==TIMEOUT-1: go to ERR, req ← 0, timeout_err ← 1.
    - Otherwise wcnt increments.
  - Grant may come and go cycle by cycle (the arbiter token rotates); only granted cycles count as beats.
- **GAP:** req=0, busy=1; counts GAP cycles, then goes to IDLE.
- **ERR:** req=0, busy=1, timeout_err=1. clr_err[i]=1 moves the channel to IDLE and clears timeout_err at the same edge.
- **Ignored starts:**
  - start while not in IDLE is ignored (no queueing).
  - start coincident with clr_err in ERR is ignored.
- **gnt_err:** set at the next edge, and held until reset, if either:
  - any grant[i]=1 while req[i]=0, or
  - more than one grant bit is high in a cycle.
- **Counter widths:**
  - rem is LEN_W+1 bits.
  - wcnt is clog2(TIMEOUT)+1 bits; saturation is not required because ERR is reached first.
- **Channel independence:**
  - Channels are fully independent; all N may be in REQ simultaneously.
  - The block does not arbitrate; it trusts the arbiter except for the gnt_err checks.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, REQ=2'b01, GAP=2'b10, ERR=2'b11.
  - Default constants for LEN_W, TIMEOUT and GAP.
- One sub-module: `arb_req_channel` (single-channel FSM plus rem/wcnt/gap counters), instantiated N times via generate.
- Top level holds the `len` slicing and the gnt_err checker.

Test Plan:
1. Channel 0, start with len=2, grant[0] tied to req[0] → req[0] high for exactly 3 cycles; beat[0] high for 3 cycles; done[0] pulses once in cycle 4; busy[0] low after 1 GAP cycle.
2. Channel 1, len=1, grant[1] high only every 4th cycle (rotating-token pattern) → 2 beats; req[1] falls the cycle after the 2nd grant; timeout_err stays 0.
3. Channel 2, len=0, grant held 0 → req[2] falls after 16 cycles; timeout_err[2]=1 and busy[2]=1. Pulse clr_err[2] → next cycle busy[2]=0 and timeout_err[2]=0.
4. Spurious grant: grant[3]=1 with req[3]=0 → gnt_err=1 next cycle and stays 1. Repeat after reset with grant=4'b0011 while both reqs are high → gnt_err=1.
5. rst=0 during beat 2 of a len=3 burst → next cycle req=0, busy=0, no done pulse. A new start after reset release completes normally.
6. All 4 channels start together, len=1 each, with the real arbiter connected → each channel gets exactly 2 beats and each done pulses once; gnt_err=0. A start[0] pulse during channel 0's burst is ignored.
